fp_operand_issue: RTL and testbench
===================================

Name: fp_operand_issue

Overview:
- Input stage directly upstream of the combinational single-precision add/sub datapath.
- Accepts operand pairs (a, b, op) over a valid/ready handshake and classifies both operands.
- Flushes denormals to signed zero and resolves NaN/Inf cases, which the datapath cannot handle, to a bypass result.
- Presents registered, back-pressurable operands to the datapath through a 2-entry skid buffer, giving full throughput with registered in_ready.

Parameters:
TAG_W, 4, width of opaque tag carried alongside each operand pair
QNAN, 32'h7FC0_0000, canonical quiet NaN emitted for invalid/NaN cases

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  operand pair offered
in_ready  out  1  stage can accept; registered
in_a  in  32  operand a, IEEE-754 single
in_b  in  32  operand b, IEEE-754 single
in_op  in  1  0 = a+b, 1 = a-b
in_tag  in  TAG_W  opaque tag
out_valid  out  1  issued pair valid
out_ready  in  1  downstream accepts
out_a  out  32  sanitised operand a
out_b  out  32  sanitised operand b
out_op  out  1  op passthrough
out_tag  out  TAG_W  tag passthrough
out_special  out  1  1 = out_special_val is the final result; datapath output must be ignored
out_special_val  out  32  bypass result, 0 when out_special = 0

Behaviour:
- Reset (rst low, asynchronous): state EMPTY; out_valid = 0; in_ready = 1; all data outputs = 0. Deassertion is synchronised externally.
- Accept: in_valid & in_ready at a rising edge. Issue: out_valid & out_ready at a rising edge.
- Data/latency: outputs come only from the main register. Accept-to-out_valid latency is 1 cycle. Sustained throughput is 1 pair/cycle.
- State EMPTY: main and skid empty; in_ready = 1.
  - Accept -> ONE.
- State ONE: main full; in_ready = 1.
  - Issue without accept -> EMPTY.
  - Accept with issue -> ONE; main loads the new pair.
  - Accept without issue -> TWO; new pair goes to skid.
- State TWO: main and skid full; in_ready = 0.
  - Issue -> ONE; main loads skid.
  - No accept is possible in this state.
- in_ready is a register: cleared on entry to TWO, set on leaving TWO. No combinational path from out_ready to in_ready.
- out_valid stays high and all out_* stay stable until issued. in_valid dropping never affects held data.
- Classification is done on the fly on accept; the classified result is stored. Field widths: exp = f[30:23], man = f[22:0].
  - exp == 0: class ZERO. Operand is replaced with {sign, 31'b0}, i.e. denormal flushed, sign kept.
  - exp == 8'hFF, man != 0: class NAN.
  - exp == 8'hFF, man == 0: class INF.
  - Otherwise: class NORM; operand unchanged.
- Special resolution. Effective sign of b is sb' = sb ^ op.
  - Either operand NAN: special = 1, val = QNAN.
  - Both INF and sa != sb': special = 1, val = QNAN.
  - Both INF and sa == sb': special = 1, val = {sa, 8'hFF, 23'b0}.
  - a INF only: special = 1, val = a.
  - b INF only: special = 1, val = {sb', 8'hFF, 23'b0}.
  - Otherwise special = 0 and val = 0. ZERO/NORM pairs always go to the datapath.
- When special = 1, out_a/out_b/out_op still carry the sanitised operands; the consumer muxes on out_special.
- Mid-operation reset empties both entries immediately. No partial issue; pending pairs are lost.

Decomposition:
- Shared package fp_pkg:
  - FP_EXP_W = 8, FP_MAN_W = 23, FP_EXP_MAX = 8'hFF.
  - QNAN constant.
  - enum fp_class_t {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
  - packed struct fp_issue_t {a, b, op, tag, special, special_val}, used for the main and skid registers.
- One combinational sub-module, fp_classify (32-bit in -> fp_class_t, sanitised 32-bit out), instantiated twice.
- Special resolution and skid FSM live in the top module.

Test Plan:
1. Basic: a = 32'h3F80_0000, b = 32'h4000_0000, op = 0 with out_ready = 1 -> next cycle out_valid = 1, same a/b, special = 0; in_ready stays 1.
2. Back-pressure: out_ready = 0 and 3 back-to-back offers -> first two accepted, in_ready = 0 after the second. Then out_ready = 1 -> pairs issue in order, then the third follows; no loss or duplication, tags in order 0, 1, 2.
3. Denormal: a = 32'h8000_0001, b = 32'h3F80_0000 -> out_a = 32'h8000_0000, special = 0.
4. Inf - Inf: a = 32'h7F80_0000, b = 32'h7F80_0000, op = 1 -> special = 1, val = 32'h7FC0_0000. With op = 0 -> val = 32'h7F80_0000. Finite a = 1.0, b = +Inf, op = 1 -> val = 32'hFF80_0000.
5. NaN: a = 32'h7F80_0001, b = 1.0 -> special = 1, val = 32'h7FC0_0000.
6. Reset mid-stream: state TWO, assert rst low between edges -> out_valid = 0 and in_ready = 1 immediately, data outputs 0. After release, a new pair is issued with 1-cycle latency.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision operand issue stage.
// Holds IEEE-754 field widths, the canonical quiet NaN, the operand class
// enum and the packed record held in the issue stage's main/skid registers.
package fp_pkg;

  localparam int          FP_EXP_W   = 8;
  localparam int          FP_MAN_W   = 23;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  // Tag width carried in the stored record.
  localparam int          FP_TAG_W   = 4;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef struct packed {
    logic [31:0]         a;
    logic [31:0]         b;
    logic                op;
    logic [FP_TAG_W-1:0] tag;
    logic                special;
    logic [31:0]         special_val;
  } fp_issue_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier.
// Ports:
//   f      in  32  operand
//   cls    out     class (ZERO, NORM, INF, NAN)
//   f_san  out 32  sanitised operand: exp == 0 flushed to signed zero,
//                  everything else passed through unchanged
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] f,
  output fp_class_t   cls,
  output logic [31:0] f_san
);

  logic [FP_EXP_W-1:0] exp_f;
  logic [FP_MAN_W-1:0] man_f;

  assign exp_f = f[30:23];
  assign man_f = f[22:0];

  always_comb begin
    cls   = FP_NORM;
    f_san = f;
    if (exp_f == '0) begin
      // Denormals are not supported downstream; keep only the sign.
      cls   = FP_ZERO;
      f_san = {f[31], 31'b0};
    end else if (exp_f == FP_EXP_MAX) begin
      cls = (man_f != '0) ? FP_NAN : FP_INF;
    end
  end

endmodule

// File: rtl/fp_operand_issue.sv
// Operand issue stage in front of the combinational add/sub datapath.
// Classifies both operands on accept, flushes denormals, resolves NaN/Inf
// cases to a bypass result and presents the pair through a 2-entry skid
// buffer so in_ready can be a register while keeping 1 pair/cycle.
// Ports:
//   clk, rst                 clock, async active-low reset
//   in_valid/in_ready        upstream handshake (in_ready registered)
//   in_a, in_b, in_op, in_tag  operand pair, op (0 add, 1 sub), tag
//   out_valid/out_ready      downstream handshake
//   out_a, out_b, out_op, out_tag  sanitised operands from the main register
//   out_special, out_special_val   bypass flag and bypass result
//
// state   | meaning
// S_EMPTY | main and skid empty, in_ready = 1
// S_ONE   | main full, skid empty, in_ready = 1
// S_TWO   | main and skid full, in_ready = 0
module fp_operand_issue
  import fp_pkg::*;
#(
  // Stored tag width is FP_TAG_W; TAG_W is expected to match it.
  parameter int          TAG_W = FP_TAG_W,
  parameter logic [31:0] QNAN  = FP_QNAN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic             out_op,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_special,
  output logic [31:0]      out_special_val
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t    state_q, state_d;
  fp_issue_t main_q, main_d;
  fp_issue_t skid_q, skid_d;
  logic      in_ready_q, in_ready_d;
  logic      out_valid_q, out_valid_d;

  fp_class_t   cls_a, cls_b;
  logic [31:0] a_san, b_san;
  fp_issue_t   new_pair;
  logic        sb_eff;
  logic        accept, issue;

  fp_classify u_cls_a (.f(in_a), .cls(cls_a), .f_san(a_san));
  fp_classify u_cls_b (.f(in_b), .cls(cls_b), .f_san(b_san));

  // Subtraction is addition with b's sign flipped, so Inf resolution uses it.
  assign sb_eff = in_b[31] ^ in_op;

  always_comb begin
    new_pair             = '0;
    new_pair.a           = a_san;
    new_pair.b           = b_san;
    new_pair.op          = in_op;
    new_pair.tag         = FP_TAG_W'(in_tag);
    new_pair.special     = 1'b0;
    new_pair.special_val = '0;
    if (cls_a == FP_NAN || cls_b == FP_NAN) begin
      new_pair.special     = 1'b1;
      new_pair.special_val = QNAN;
    end else if (cls_a == FP_INF && cls_b == FP_INF) begin
      new_pair.special     = 1'b1;
      new_pair.special_val = (in_a[31] != sb_eff) ? QNAN : {in_a[31], FP_EXP_MAX, 23'b0};
    end else if (cls_a == FP_INF) begin
      new_pair.special     = 1'b1;
      new_pair.special_val = in_a;
    end else if (cls_b == FP_INF) begin
      new_pair.special     = 1'b1;
      new_pair.special_val = {sb_eff, FP_EXP_MAX, 23'b0};
    end
  end

  assign accept = in_valid & in_ready_q;
  assign issue  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = new_pair;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && issue) begin
          main_d = new_pair;
        end else if (accept) begin
          skid_d  = new_pair;
          state_d = S_TWO;
        end else if (issue) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (issue) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_a           = main_q.a;
  assign out_b           = main_q.b;
  assign out_op          = main_q.op;
  assign out_tag         = TAG_W'(main_q.tag);
  assign out_special     = main_q.special;
  assign out_special_val = main_q.special_val;

endmodule

// File: tb/tb_fp_operand_issue.sv
module tb_fp_operand_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_op = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic        out_op;
  logic [3:0]  out_tag;
  logic        out_special;
  logic [31:0] out_special_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_operand_issue #(.TAG_W(4), .QNAN(32'h7FC0_0000)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_tag(out_tag),
    .out_special(out_special), .out_special_val(out_special_val)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [3:0]  tag;
    logic        sp;
    logic [31:0] val;
  } exp_t;

  // Reference: FIFO of expected issued records; its length is the occupancy.
  exp_t mq[$];

  function automatic exp_t ref_issue(input logic [31:0] a, input logic [31:0] b,
                                     input logic op, input logic [3:0] tag);
    exp_t e;
    logic a_nan, b_nan, a_inf, b_inf, sbe;
    a_nan = (a[30:23] == 8'd255) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'd255) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'd255) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'd255) && (b[22:0] == 0);
    sbe   = b[31] ^ op;
    e.a   = (a[30:23] == 0) ? {a[31], 31'b0} : a;
    e.b   = (b[30:23] == 0) ? {b[31], 31'b0} : b;
    e.op  = op;
    e.tag = tag;
    e.sp  = 1'b1;
    if (a_nan || b_nan)       e.val = 32'h7FC0_0000;
    else if (a_inf && b_inf)  e.val = (a[31] != sbe) ? 32'h7FC0_0000 : {a[31], 8'hFF, 23'b0};
    else if (a_inf)           e.val = a;
    else if (b_inf)           e.val = {sbe, 8'hFF, 23'b0};
    else begin
      e.sp  = 1'b0;
      e.val = 32'h0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'h00;
      1: r[30:0]  = {8'hFF, 23'b0};
      2: begin r[30:23] = 8'hFF; if (r[22:0] == 0) r[0] = 1'b1; end
      default: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'h80;
    endcase
    return r;
  endfunction

  function automatic exp_t dut_rec();
    return {out_a, out_b, out_op, out_tag, out_special, out_special_val};
  endfunction

  // Drives one cycle starting at a negedge and ends at the next negedge;
  // the model follows the handshake rules of a 2-deep FIFO.
  task automatic drive_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                             input logic op, input logic [3:0] tag, input logic ordy);
    logic acc, iss;
    in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag; out_ready = ordy;
    acc = v && (mq.size() < 2);
    iss = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (iss) void'(mq.pop_front());
    if (acc) mq.push_back(ref_issue(a, b, op, tag));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++;
    if (dut_rec() !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", dut_rec()); end
  endtask

  task automatic test_basic();
    drive_cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'h5, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    n_tests++;
    if ({out_a, out_b, out_special} !== {32'h3F80_0000, 32'h4000_0000, 1'b0}) begin
      n_fail++; $display("FAIL basic_data got=%h/%h/%b exp=3f800000/40000000/0", out_a, out_b, out_special);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    drive_cycle(1'b0, 0, 0, 0, 0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure();
    logic [3:0] got[$];
    bit         acc2;
    drive_cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd0, 1'b0);
    drive_cycle(1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b1, 4'd1, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    drive_cycle(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 4'd2, 1'b0);
    n_tests++;
    if (out_tag !== 4'd0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold got=%0d/%b exp=0/1", out_tag, out_valid);
    end
    acc2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) got.push_back(out_tag);
      if (!acc2 && in_ready === 1'b1) begin
        acc2 = 1'b1;
        drive_cycle(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 4'd2, 1'b1);
      end else begin
        drive_cycle(!acc2, 32'h4040_0000, 32'h3F80_0000, 1'b0, 4'd2, 1'b1);
      end
    end
    n_tests++;
    if (got.size() != 3 || got[0] !== 4'd0 || got[1] !== 4'd1 || got[2] !== 4'd2) begin
      n_fail++; $display("FAIL bp_order got=%p exp='{0,1,2}", got);
    end
  endtask

  task automatic test_denormal();
    drive_cycle(1'b1, 32'h8000_0001, 32'h3F80_0000, 1'b0, 4'h3, 1'b1);
    n_tests++;
    if ({out_a, out_special} !== {32'h8000_0000, 1'b0}) begin
      n_fail++; $display("FAIL denorm got=%h/%b exp=80000000/0", out_a, out_special);
    end
    drive_cycle(1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_specials();
    logic [31:0] va[4]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0001};
    logic [31:0] vb[4]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000};
    logic        vo[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] vx[4]  = '{32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, va[i], vb[i], vo[i], 4'(i), 1'b1);
      n_tests++;
      if ({out_special, out_special_val} !== {1'b1, vx[i]}) begin
        n_fail++; $display("FAIL special_%0d got=%b/%h exp=1/%h", i, out_special, out_special_val, vx[i]);
      end
    end
    drive_cycle(1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      n_tests++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
        errs++; n_fail++;
        if (errs < 10) $display("FAIL rand_hs cyc=%0d got v=%b r=%b exp occupancy=%0d", i, out_valid, in_ready, mq.size());
      end else if (mq.size() > 0 && dut_rec() !== mq[0]) begin
        errs++; n_fail++;
        if (errs < 10) $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, dut_rec(), mq[0]);
      end
      drive_cycle($urandom_range(0, 3) != 0, rand_fp(), rand_fp(), 1'($urandom),
                  4'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 0, 0, 0, 0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      n_fail++; $display("FAIL rand_drain got v=%b exp=0 (model %0d)", out_valid, mq.size());
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd7, 1'b0);
    drive_cycle(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 4'd8, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_two got=%b exp=0", in_ready); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_rec() !== '0) begin
      n_fail++; $display("FAIL rmid_async got v=%b r=%b d=%h exp 0/1/0", out_valid, in_ready, dut_rec());
    end
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive_cycle(1'b1, 32'h4040_0000, 32'hC000_0000, 1'b1, 4'd9, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || dut_rec() !== ref_issue(32'h4040_0000, 32'hC000_0000, 1'b1, 4'd9)) begin
      n_fail++; $display("FAIL rmid_after got v=%b d=%h", out_valid, dut_rec());
    end
    drive_cycle(1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_basic();
    test_back_pressure();
    test_denormal();
    test_specials();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
